text_console_renderer: RTL and testbench
========================================

// Module: text_console_renderer
// PURPOSE
//  Parametrised text-mode console for the VGA path: accepts ASCII bytes over a valid/ready port, stores them in a ROWS x COLS
//  character buffer with cursor, newline, backspace and clear handling, and renders the buffer as a pixel window via the
//  external ascii_rom (8x16 glyphs, 1-clk read latency). Sits between the switch/button input logic and the vga_controller rgb mux.
// PARAMETERS
//  COLS  16      characters per line (1..80)
//  ROWS  4       lines (1..30)
//  X0    192     left pixel column of the text window
//  Y0    208     top pixel row of the text window
//  FG    12'h00F glyph pixel colour
//  BG    12'hFFF background colour (in-window and out-of-window)
// PORTS
//  clk         in   1   pixel clock; single clock domain
//  reset_n     in   1   asynchronous, active-low reset
//  char_valid  in   1   char_data is offered this cycle
//  char_data   in   8   ASCII byte
//  char_ready  out  1   block accepts char_data when char_valid & char_ready
//  clear_req   in   1   single-cycle pulse: blank the whole buffer, cursor home
//  video_on    in   1   from vga_controller
//  x, y        in   10  current pixel coordinates
//  rom_addr    out  11  {char[6:0], glyph_row[3:0]} to ascii_rom
//  rom_data    in   8   glyph row from ascii_rom, valid 1 clk after rom_addr
//  cur_col     out  $clog2(COLS)  cursor column
//  cur_row     out  $clog2(ROWS)  cursor line
//  rgb         out  12  registered pixel colour
// BEHAVIOUR
//  Reset: rgb=0, char_ready=0, cursor=(0,0), FSM enters CLEAR.
//  FSM: CLEAR -> IDLE.  CLEAR writes 0x20 to one cell per clk, ROWS*COLS clks, char_ready=0; then IDLE, char_ready=1.
//   clear_req or accepted 0x0C in IDLE -> CLEAR, cursor home. clear_req with char_valid same cycle: clear wins, byte not accepted.
//   reset_n low mid-CLEAR restarts CLEAR from cell 0 after release.
//  Accepted byte (IDLE only, one per clk, no back-to-back stall):
//   0x20..0x7E: write at cursor, cursor advances.   other non-control bytes: write 0x2D ('-'), advance.
//   0x0A/0x0D: col=0, row+1.   0x08: retreat one cell and write 0x20; at (0,0) no-op.
//   Advance past COLS-1 -> col 0, row+1; row+1 past ROWS-1 -> row 0 (wrap, no erase).
//   Backspace at col 0, row r>0 -> (COLS-1, r-1).
//  Render pipeline, latency 3 clk from (x,y) to rgb:
//   S0: in_win = x>=X0 && x<X0+8*COLS && y>=Y0 && y<Y0+16*ROWS; cell = ((y-Y0)>>4, (x-X0)>>3); buffer read registered.
//   S1: rom_addr = {code[6:0], (y-Y0)[3:0]} from registered code; bit index, in_win, video_on delayed alongside.
//   S2: rgb <= ~video_on_d ? 0 : (!in_win_d ? BG : rom_data[7-bit_idx] ? FG : BG).
//  Buffer write (writer) and read (renderer) share a dual-port array; same-cell collision renders old or new code, no glitch.
//  Subtraction uses 11-bit signed compare; never index the buffer outside the window.
// CONFIGURATION
//  CURSOR_BLINK_EN defined: 24-bit free counter; while bit 23 = 1, glyph rows 14-15 of the cursor cell render FG (underline).
//  Undefined: no cursor drawn; counter absent; cur_col/cur_row outputs still present.
// STRUCTURE
//  Package text_console_pkg: ASCII_SPACE/DASH/BS/LF/CR/FF constants, state enum {ST_CLEAR, ST_IDLE}, GLYPH_W=8, GLYPH_H=16.
//  Sub-module text_console_pixel_pipe: S0-S2 render pipeline and cursor overlay; top holds FSM, cursor, buffer.
// TESTING
//  Reset release -> char_ready low exactly ROWS*COLS clks, then 1; every cell reads 0x20; rgb in-window = BG.
//  Send "A" (0x41) -> cell(0,0)=0x41, cursor (0,1); pixel x=X0..X0+7,y=Y0+3 after 3 clk matches ascii_rom 'A' row 3 in FG/BG.
//  Send 17 bytes with COLS=16 -> 17th lands at (1,0); ROWS*COLS+1 bytes -> last at (0,0) (wrap).
//  Send 0x08 at (1,0) -> cursor (0,15), cell 0x20; 0x08 at (0,0) -> no change.
//  Send 0x07 -> stored 0x2D; send 0x0D at (2,5) -> cursor (3,0).
//  clear_req with char_valid same clk -> byte dropped, full CLEAR, cursor (0,0); video_on=0 -> rgb=0 3 clk later.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants, FSM state type and width helper for the text console renderer.
package text_console_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_FF    = 8'h0C;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   // Width of an index over n items, never below one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/text_console_pixel_pipe.sv
// Three-stage pixel pipeline: window/cell decode, glyph ROM address, colour select.
// Cursor underline is drawn only when CURSOR_BLINK_EN is defined.
module text_console_pixel_pipe
   import text_console_pkg::*;
#(
   parameter int          COLS = 16,
   parameter int          ROWS = 4,
   parameter int          X0   = 192,
   parameter int          Y0   = 208,
   parameter logic [11:0] FG   = 12'h00F,
   parameter logic [11:0] BG   = 12'hFFF,
   parameter int          AW   = width_of(COLS * ROWS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          video_on,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   input  logic [AW-1:0] cur_idx,
   output logic [AW-1:0] rd_addr,
   input  logic [6:0]    rd_code,
   output logic [10:0]   rom_addr,
   input  logic [7:0]    rom_data,
   output logic [11:0]   rgb
);

   localparam logic signed [10:0] X0S   = 11'(X0);
   localparam logic signed [10:0] Y0S   = 11'(Y0);
   localparam logic signed [10:0] WIN_W = 11'(GLYPH_W * COLS);
   localparam logic signed [10:0] WIN_H = 11'(GLYPH_H * ROWS);

   logic signed [10:0] dx, dy;
   logic               in_win, cur_hit, blink_on;
   logic [6:0]         cell_col;
   logic [5:0]         cell_row;
   logic [AW-1:0]      cell_idx;

   logic               in_win_1, vid_1, ul_1;
   logic [3:0]         row_1;
   logic [2:0]         bit_1;
   logic               in_win_2, vid_2, ul_2;
   logic [2:0]         bit_2;

   // S0: signed offsets keep pixels left of / above the window out of the buffer.
   assign dx       = $signed({1'b0, x}) - X0S;
   assign dy       = $signed({1'b0, y}) - Y0S;
   assign in_win   = (dx >= 11'sd0) && (dx < WIN_W) && (dy >= 11'sd0) && (dy < WIN_H);
   assign cell_col = dx[9:3];
   assign cell_row = dy[9:4];
   assign cell_idx = AW'(cell_row) * AW'(COLS) + AW'(cell_col);
   assign rd_addr  = in_win ? cell_idx : '0;
   assign cur_hit  = in_win && (cell_idx == cur_idx) && (dy[3:0] >= 4'd14);

`ifdef CURSOR_BLINK_EN
   logic [23:0] blink_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) blink_cnt <= '0;
      else          blink_cnt <= blink_cnt + 24'd1;
   end

   assign blink_on = blink_cnt[23];
`else
   assign blink_on = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_win_1 <= 1'b0;
         vid_1    <= 1'b0;
         ul_1     <= 1'b0;
         row_1    <= '0;
         bit_1    <= '0;
         in_win_2 <= 1'b0;
         vid_2    <= 1'b0;
         ul_2     <= 1'b0;
         bit_2    <= '0;
         rgb      <= '0;
      end else begin
         in_win_1 <= in_win;
         vid_1    <= video_on;
         ul_1     <= cur_hit && blink_on;
         row_1    <= dy[3:0];
         bit_1    <= dx[2:0];
         in_win_2 <= in_win_1;
         vid_2    <= vid_1;
         ul_2     <= ul_1;
         bit_2    <= bit_1;
         if (!vid_2)
            rgb <= '0;
         else if (!in_win_2)
            rgb <= BG;
         else if (ul_2 || rom_data[3'd7 - bit_2])
            rgb <= FG;
         else
            rgb <= BG;
      end
   end

   // S1: the buffer read registered this stage's code; the ROM answers one clock later.
   assign rom_addr = {rd_code, row_1};

endmodule

// File: rtl/text_console_renderer.sv
// Text console: byte intake FSM, cursor, character buffer, and the pixel pipeline.
// Optional cursor underline is enabled by defining CURSOR_BLINK_EN.
module text_console_renderer
   import text_console_pkg::*;
#(
   parameter int          COLS = 16,
   parameter int          ROWS = 4,
   parameter int          X0   = 192,
   parameter int          Y0   = 208,
   parameter logic [11:0] FG   = 12'h00F,
   parameter logic [11:0] BG   = 12'hFFF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        char_valid,
   input  logic [7:0]                  char_data,
   output logic                        char_ready,
   input  logic                        clear_req,
   input  logic                        video_on,
   input  logic [9:0]                  x,
   input  logic [9:0]                  y,
   output logic [10:0]                 rom_addr,
   input  logic [7:0]                  rom_data,
   output logic [width_of(COLS)-1:0]   cur_col,
   output logic [width_of(ROWS)-1:0]   cur_row,
   output logic [11:0]                 rgb,
   output logic                        fsm_state
);

   localparam int CELLS = ROWS * COLS;
   localparam int AW    = width_of(CELLS);
   localparam int CW    = width_of(COLS);
   localparam int RW    = width_of(ROWS);

   // Handshake: a byte moves when char_valid && char_ready at a rising edge and
   // clear_req is low; char_ready is registered and high only in ST_IDLE.
   state_t          state;
   logic [AW-1:0]   clr_idx, cur_idx, waddr, rd_addr;
   logic            we, accept, at_home, printable;
   logic [6:0]      wdata, rd_code;
   logic [6:0]      mem [CELLS];
   logic [CW-1:0]   adv_col, bs_col;
   logic [RW-1:0]   adv_row, bs_row, nl_row;

   assign fsm_state = state;
   assign cur_idx   = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
   assign accept    = (state == ST_IDLE) && char_ready && char_valid && !clear_req;
   assign at_home   = (cur_col == '0) && (cur_row == '0);
   assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

   always_comb begin
      nl_row  = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
      adv_col = cur_col + 1'b1;
      adv_row = cur_row;
      if (cur_col == CW'(COLS - 1)) begin
         adv_col = '0;
         adv_row = nl_row;
      end
      bs_col = cur_col - 1'b1;
      bs_row = cur_row;
      if (cur_col == '0) begin
         bs_col = CW'(COLS - 1);
         bs_row = cur_row - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CLEAR;
         char_ready <= 1'b0;
         cur_col    <= '0;
         cur_row    <= '0;
         clr_idx    <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_idx == AW'(CELLS - 1)) begin
                  state      <= ST_IDLE;
                  char_ready <= 1'b1;
                  clr_idx    <= '0;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            ST_IDLE: begin
               if (clear_req || (accept && char_data == ASCII_FF)) begin
                  state      <= ST_CLEAR;
                  char_ready <= 1'b0;
                  cur_col    <= '0;
                  cur_row    <= '0;
                  clr_idx    <= '0;
               end else if (accept) begin
                  case (char_data)
                     ASCII_LF, ASCII_CR: begin
                        cur_col <= '0;
                        cur_row <= nl_row;
                     end
                     ASCII_BS: begin
                        if (!at_home) begin
                           cur_col <= bs_col;
                           cur_row <= bs_row;
                        end
                     end
                     default: begin
                        cur_col <= adv_col;
                        cur_row <= adv_row;
                     end
                  endcase
               end
            end
            default: begin
               state      <= ST_CLEAR;
               char_ready <= 1'b0;
               clr_idx    <= '0;
            end
         endcase
      end
   end

   // Backspace always erases the flat index just before the cursor, which also
   // covers the step from column 0 back to the end of the previous line.
   always_comb begin
      we    = 1'b0;
      waddr = cur_idx;
      wdata = ASCII_SPACE[6:0];
      if (state == ST_CLEAR) begin
         we    = 1'b1;
         waddr = clr_idx;
      end else if (accept) begin
         case (char_data)
            ASCII_FF, ASCII_LF, ASCII_CR: ;
            ASCII_BS: begin
               we    = !at_home;
               waddr = cur_idx - 1'b1;
            end
            default: begin
               we    = 1'b1;
               wdata = printable ? char_data[6:0] : ASCII_DASH[6:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd_code <= mem[rd_addr];
   end

   text_console_pixel_pipe #(
      .COLS (COLS),
      .ROWS (ROWS),
      .X0   (X0),
      .Y0   (Y0),
      .FG   (FG),
      .BG   (BG),
      .AW   (AW)
   ) u_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .video_on (video_on),
      .x        (x),
      .y        (y),
      .cur_idx  (cur_idx),
      .rd_addr  (rd_addr),
      .rd_code  (rd_code),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rgb      (rgb)
   );

endmodule

// File: tb/tb_text_console_renderer.sv
// Bench for text_console_renderer: directed bytes and pixel probes, expected-queue scoreboard.
module tb_text_console_renderer;
   import text_console_pkg::*;

   localparam int          COLS  = 16;
   localparam int          ROWS  = 4;
   localparam int          CELLS = COLS * ROWS;
   localparam int          X0    = 192;
   localparam int          Y0    = 208;
   localparam logic [11:0] FG    = 12'h00F;
   localparam logic [11:0] BG    = 12'hFFF;
   localparam int K_RGB = 0, K_READY = 1, K_CURSOR = 2, K_ROM = 3;

   logic        clk, reset_n, char_valid, char_ready, clear_req, video_on, fsm_state;
   logic [7:0]  char_data, rom_data;
   logic [9:0]  x, y;
   logic [10:0] rom_addr;
   logic [3:0]  cur_col;
   logic [1:0]  cur_row;
   logic [11:0] rgb;

   text_console_renderer #(
      .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .FG(FG), .BG(BG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .clear_req(clear_req), .video_on(video_on), .x(x), .y(y),
      .rom_addr(rom_addr), .rom_data(rom_data), .cur_col(cur_col), .cur_row(cur_row),
      .rgb(rgb), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- glyph ROM model (1 clk latency) ----------------
   function automatic logic [7:0] rom_fn(input logic [10:0] a);
      logic [6:0] code;
      logic [3:0] r;
      code = a[10:4];
      r    = a[3:0];
      if (code == 7'h20) return 8'h00;
      if (code == 7'h41) begin
         case (r)
            4'd2: return 8'h10;
            4'd3: return 8'h38;
            4'd4: return 8'h6C;
            4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: return 8'hC6;
            4'd7: return 8'hFE;
            default: return 8'h00;
         endcase
      end
      return {code[3:0], r} ^ {r, code[3:0]};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   int          due_q[$];
   int          kind_q[$];
   int          checks = 0;
   int          failures = 0;

   task automatic expect_at(input int due, input int kind, input logic [15:0] v);
      exp_q.push_back(v);
      due_q.push_back(due);
      kind_q.push_back(kind);
   endtask

   function automatic string kname(input int k);
      case (k)
         K_RGB:    return "rgb";
         K_READY:  return "char_ready";
         K_CURSOR: return "cursor_row_col";
         default:  return "rom_addr";
      endcase
   endfunction

   function automatic logic [15:0] actual(input int k);
      case (k)
         K_RGB:    return 16'(rgb);
         K_READY:  return 16'(char_ready);
         K_CURSOR: return {8'(cur_row), 8'(cur_col)};
         default:  return 16'(rom_addr);
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      logic [15:0] a;
      for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
         if (due_q[i] <= cyc) begin
            a = actual(kind_q[i]);
            checks++;
            if (a !== exp_q[i] || due_q[i] != cyc) begin
               failures++;
               $display("FAIL %s cyc=%0d due=%0d actual=%h expected=%h",
                        kname(kind_q[i]), cyc, due_q[i], a, exp_q[i]);
            end
            exp_q.delete(i);
            due_q.delete(i);
            kind_q.delete(i);
         end
      end
   end

   // ---------------- reference model ----------------
   int         m_row, m_col;
   logic [6:0] shadow [CELLS];

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) shadow[i] = 7'h20;
      m_row = 0;
      m_col = 0;
   endtask

   task automatic model_advance();
      if (m_col == COLS - 1) begin
         m_col = 0;
         m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'h0A || b == 8'h0D) begin
         m_col = 0;
         m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end else if (b == 8'h08) begin
         if (!(m_row == 0 && m_col == 0)) begin
            if (m_col == 0) begin
               m_col = COLS - 1;
               m_row--;
            end else begin
               m_col--;
            end
            shadow[m_row * COLS + m_col] = 7'h20;
         end
      end else begin
         shadow[m_row * COLS + m_col] = (b >= 8'h20 && b <= 8'h7E) ? b[6:0] : 7'h2D;
         model_advance();
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_clear_window(input int a);
      expect_at(a, K_READY, 16'd0);
      expect_at(a + CELLS - 1, K_READY, 16'd0);
      expect_at(a + CELLS, K_READY, 16'd1);
      expect_at(a, K_CURSOR, 16'h0000);
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      char_valid = 1'b1;
      char_data  = b;
      while (!char_ready && t < 300) begin
         tick();
         t++;
      end
      checks++;
      if (!char_ready) begin
         failures++;
         $display("FAIL send_ready_timeout byte=%h actual=0 required=1", b);
         char_valid = 1'b0;
         return;
      end
      tick();
      char_valid = 1'b0;
      if (b == 8'h0C) begin
         model_clear();
         expect_clear_window(cyc);
      end else begin
         model_byte(b);
         expect_at(cyc, K_CURSOR, {8'(m_row), 8'(m_col)});
      end
   endtask

   task automatic probe(input int px, input int py, input logic vid);
      int          dx, dy;
      logic [10:0] ra;
      logic [7:0]  g;
      logic [11:0] e;
      x        = 10'(px);
      y        = 10'(py);
      video_on = vid;
      dx = px - X0;
      dy = py - Y0;
      e  = BG;
      if (dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 16 * ROWS) begin
         ra = {shadow[(dy / 16) * COLS + dx / 8], 4'(dy % 16)};
         expect_at(cyc + 1, K_ROM, 16'(ra));
         g = rom_fn(ra);
         e = g[7 - (dx % 8)] ? FG : BG;
      end
      if (!vid) e = 12'h000;
      expect_at(cyc + 3, K_RGB, 16'(e));
      tick();
   endtask

   task automatic probe_cell(input int r, input int c, input int gr);
      for (int i = 0; i < 8; i++) probe(X0 + 8 * c + i, Y0 + 16 * r + gr, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int a;
      reset_n    = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      clear_req  = 1'b0;
      video_on   = 1'b1;
      x          = 10'd0;
      y          = 10'd0;
      model_clear();
      tick();
      tick();
      expect_at(cyc, K_RGB, 16'h0000);
      expect_at(cyc, K_READY, 16'd0);
      tick();

      // Release, then re-assert reset part-way through the clear.
      reset_n = 1'b1;
      repeat (20) tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      expect_clear_window(cyc);
      repeat (CELLS + 2) tick();

      // Whole buffer blank, window edges and outside render BG.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            probe(X0 + 8 * c + (c % 8), Y0 + 16 * r + ((r * 5 + c) % 16), 1'b1);
      probe(X0 - 1, Y0, 1'b1);
      probe(X0, Y0 - 1, 1'b1);
      probe(X0 + 8 * COLS, Y0 + 5, 1'b1);
      probe(X0 + 5, Y0 + 16 * ROWS, 1'b1);
      probe(10, 10, 1'b1);

      // 'A' at home; row 3 of the glyph is 8'h38.
      send(8'h41);
      expect_at(cyc, K_CURSOR, 16'h0001);
      probe_cell(0, 0, 3);

      // Fill the first line, step back across the line boundary, refill.
      for (int i = 1; i < COLS; i++) send(8'(8'h41 + i));
      expect_at(cyc, K_CURSOR, 16'h0100);
      send(8'h08);
      expect_at(cyc, K_CURSOR, 16'h000F);
      probe_cell(0, 15, 3);
      send(8'h51);
      send(8'h52);
      expect_at(cyc, K_CURSOR, 16'h0101);
      probe_cell(1, 0, 6);

      // Non-printables become '-'.
      send(8'h07);
      send(8'hC8);
      probe_cell(1, 1, 4);
      probe_cell(1, 2, 9);

      // Form feed clears; backspace at home is a no-op.
      send(8'h0C);
      send(8'h08);
      expect_at(cyc, K_CURSOR, 16'h0000);
      probe_cell(0, 0, 3);

      // Carriage return from (2,5), line feed wrap from the last row.
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
      expect_at(cyc, K_CURSOR, 16'h0205);
      send(8'h0D);
      expect_at(cyc, K_CURSOR, 16'h0300);
      send(8'h0A);
      expect_at(cyc, K_CURSOR, 16'h0000);
      probe_cell(2, 4, 2);

      // ROWS*COLS+1 bytes wrap to home without erasing.
      send(8'h0C);
      for (int i = 0; i <= CELLS; i++) send(8'(8'h21 + (i % 90)));
      expect_at(cyc, K_CURSOR, 16'h0001);
      probe_cell(0, 0, 5);
      probe_cell(0, 1, 5);
      probe_cell(3, 15, 7);

      // clear_req beats a simultaneous byte.
      char_valid = 1'b1;
      char_data  = 8'h5A;
      clear_req  = 1'b1;
      tick();
      char_valid = 1'b0;
      clear_req  = 1'b0;
      model_clear();
      a = cyc;
      expect_clear_window(a);
      repeat (CELLS + 2) tick();
      expect_at(cyc, K_CURSOR, 16'h0000);
      probe_cell(0, 0, 5);
      probe_cell(0, 1, 5);

      // Blanking forces black regardless of window.
      probe(X0 + 3, Y0 + 3, 1'b0);
      probe(5, 5, 1'b0);
      probe(X0 + 3, Y0 + 3, 1'b1);
      video_on = 1'b1;
      x = 10'd0;
      y = 10'd0;

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
      while (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_not_checked due=%0d actual=none expected=%h",
                  kname(kind_q[0]), due_q[0], exp_q[0]);
         exp_q.delete(0);
         due_q.delete(0);
         kind_q.delete(0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
